// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches one or two words, issues them.
// Define INSTR_FETCH_TRAP_UNKNOWN_EN to halt on an unknown instruction group.
package pkg_instr_dec;
    typedef enum logic [2:0] {
        instr_grp_unknown = 3'd0,
        instr_grp_1       = 3'd1,
        instr_grp_2       = 3'd2,
        instr_grp_3       = 3'd3,
        instr_grp_4       = 3'd4,
        instr_grp_5       = 3'd5
    } instr_group;
endpackage

module instr_fetch_sequencer
    import pkg_instr_dec::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr_hi,
    output logic [15:0] out_instr_lo,
    output instr_group  out_group,
    output logic [15:0] out_pc,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        illegal_instr
);

    typedef enum logic [1:0] {
        FETCH_HI,
        FETCH_LO,
        ISSUE,
        HALT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [15:0] pc;
    logic [15:0] instr_hi;
    logic [15:0] instr_lo;
    logic [15:0] pc_hi;
    instr_group group_q;
    instr_group grp_cls;
    logic       take_redirect;
    logic       hi_take;
    logic       lo_take;
    logic       trap;

    always_comb begin
        grp_cls = instr_grp_unknown;
        unique case (1'b1)
            !mem_rdata[15]:                grp_cls = instr_grp_1;
            mem_rdata[15:14] == 2'b10:     grp_cls = instr_grp_2;
            mem_rdata[15:12] == 4'b1100:   grp_cls = instr_grp_3;
            mem_rdata[15:12] == 4'b1101:   grp_cls = instr_grp_4;
            mem_rdata[15:10] == 6'b111000: grp_cls = instr_grp_5;
            default:                       grp_cls = instr_grp_unknown;
        endcase
    end

    // A redirect wins over any ack in the same cycle; HALT ignores it.
    assign take_redirect = redirect_valid && (state != HALT);
    assign hi_take = (state == FETCH_HI) && mem_ack && !redirect_valid;
    assign lo_take = (state == FETCH_LO) && mem_ack && !redirect_valid;

`ifdef INSTR_FETCH_TRAP_UNKNOWN_EN
    logic illegal_q;
    assign trap = hi_take && (grp_cls == instr_grp_unknown);
    assign illegal_instr = illegal_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else if (trap) begin
            illegal_q <= 1'b1;
        end
    end
`else
    assign trap = 1'b0;
    assign illegal_instr = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH_HI: begin
                if (redirect_valid) begin
                    state_nxt = FETCH_HI;
                end else if (mem_ack) begin
                    if (grp_cls == instr_grp_5) begin
                        state_nxt = FETCH_LO;
                    end else if (trap) begin
                        state_nxt = HALT;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            FETCH_LO: begin
                if (redirect_valid) begin
                    state_nxt = FETCH_HI;
                end else if (mem_ack) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (redirect_valid || out_ready) begin
                    state_nxt = FETCH_HI;
                end
            end
            HALT: begin
`ifdef INSTR_FETCH_TRAP_UNKNOWN_EN
                state_nxt = HALT;
`else
                state_nxt = FETCH_HI;
`endif
            end
            default: state_nxt = FETCH_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= FETCH_HI;
            pc       <= RESET_PC;
            instr_hi <= '0;
            instr_lo <= '0;
            pc_hi    <= '0;
            group_q  <= instr_grp_unknown;
        end else begin
            state <= state_nxt;
            if (take_redirect) begin
                pc <= redirect_pc;
            end else if (hi_take || lo_take) begin
                pc <= pc + 16'd1;
            end
            if (hi_take) begin
                instr_hi <= mem_rdata;
                pc_hi    <= pc;
                group_q  <= grp_cls;
                if (grp_cls != instr_grp_5) begin
                    instr_lo <= '0;
                end
            end
            if (lo_take) begin
                instr_lo <= mem_rdata;
            end
        end
    end

    assign mem_req = reset_n && ((state == FETCH_HI) || (state == FETCH_LO));
    assign mem_addr = pc;
    assign out_valid = (state == ISSUE);
    assign out_instr_hi = instr_hi;
    assign out_instr_lo = instr_lo;
    assign out_group = group_q;
    assign out_pc = pc_hi;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: directed scenarios plus a random stream
// checked against a word-level fetch model.
module tb_instr_fetch_sequencer;
    import pkg_instr_dec::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr_hi;
    logic [15:0] out_instr_lo;
    instr_group  out_group;
    logic [15:0] out_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        illegal_instr;

    logic [15:0] mem [0:65535];
    logic [15:0] ack_q [$];
    int          wait_cycles;
    bit          rand_wait;
    int          n_pass;
    int          n_total;

    always #5 clk = ~clk;

    instr_fetch_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr_hi(out_instr_hi),
        .out_instr_lo(out_instr_lo),
        .out_group(out_group),
        .out_pc(out_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .illegal_instr(illegal_instr)
    );

    // Non-pipelined memory: a request to a new address waits, then acks.
    logic [15:0] last_addr = 16'h0000;
    bit          busy = 1'b0;
    int          wcnt = 0;
    int          target = 0;
    always @(negedge clk) begin
        #1;
        mem_ack = 1'b0;
        if (mem_req) begin
            if (!busy || mem_addr != last_addr) begin
                busy = 1'b1;
                last_addr = mem_addr;
                wcnt = 0;
                target = rand_wait ? $urandom_range(0, 2) : wait_cycles;
            end
            if (wcnt >= target) begin
                mem_ack = 1'b1;
                mem_rdata = mem[mem_addr];
                ack_q.push_back(mem_addr);
                busy = 1'b0;
            end else begin
                wcnt++;
            end
        end else begin
            busy = 1'b0;
        end
    end

    function automatic instr_group ref_group(input logic [15:0] w);
        if (w < 16'h8000) return instr_grp_1;
        if (w < 16'hC000) return instr_grp_2;
        if (w < 16'hD000) return instr_grp_3;
        if (w < 16'hE000) return instr_grp_4;
        if (w < 16'hE400) return instr_grp_5;
        return instr_grp_unknown;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(input int max, output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                cyc = i + 1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        int cyc;
        wait_cycles = 0;
        mem[0] = 16'h1234;
        out_ready = 1'b0;
        do_reset();
        wait_valid(20, ok, cyc);
        n_total++;
        if (!ok) $display("FAIL reset_pre_valid: got no out_valid want out_valid");
        else n_pass++;
        reset_n = 1'b0;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0 || out_instr_hi !== 16'h0 || out_instr_lo !== 16'h0 ||
            out_group !== instr_grp_unknown || out_pc !== 16'h0 ||
            illegal_instr !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL reset_state: got v=%b hi=%h lo=%h g=%0d pc=%h ill=%b req=%b want 0/0/0/0/0/0/0",
                     out_valid, out_instr_hi, out_instr_lo, out_group, out_pc,
                     illegal_instr, mem_req);
        else n_pass++;
        wait_cycles = 10;
        reset_n = 1'b1;
        @(negedge clk);
        #2;
        n_total++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000)
            $display("FAIL reset_fetch_pc: got req=%b addr=%h want req=1 addr=0000",
                     mem_req, mem_addr);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_total++;
        if (mem_req !== 1'b0)
            $display("FAIL reset_forces_req: got %b want 0", mem_req);
        else n_pass++;
        @(negedge clk);
        wait_cycles = 0;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        mem[0] = 16'h1234;
        mem[1] = 16'h2000;
        wait_cycles = 0;
        out_ready = 1'b1;
        do_reset();
        #2;
        n_total++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || out_valid !== 1'b0)
            $display("FAIL single_cycle0: got req=%b addr=%h v=%b want 1/0000/0",
                     mem_req, mem_addr, out_valid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b1 || out_instr_hi !== 16'h1234 || out_instr_lo !== 16'h0 ||
            out_group !== instr_grp_1 || out_pc !== 16'h0000)
            $display("FAIL single_issue: got v=%b hi=%h lo=%h g=%0d pc=%h want 1/1234/0000/1/0000",
                     out_valid, out_instr_hi, out_instr_lo, out_group, out_pc);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0001 || out_valid !== 1'b0)
            $display("FAIL single_next: got req=%b addr=%h v=%b want 1/0001/0",
                     mem_req, mem_addr, out_valid);
        else n_pass++;
    endtask

    task automatic test_group5_wait();
        bit ok;
        int cyc;
        mem[16'h10] = 16'hE0AB;
        mem[16'h11] = 16'hBEEF;
        mem[16'h12] = 16'h0001;
        wait_cycles = 2;
        out_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0010;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_valid(30, ok, cyc);
        n_total++;
        if (!ok || cyc != 6)
            $display("FAIL g5_latency: got ok=%b cycles=%0d want ok=1 cycles=6", ok, cyc);
        else n_pass++;
        n_total++;
        if (out_instr_hi !== 16'hE0AB || out_instr_lo !== 16'hBEEF ||
            out_group !== instr_grp_5 || out_pc !== 16'h0010)
            $display("FAIL g5_issue: got hi=%h lo=%h g=%0d pc=%h want E0AB/BEEF/5/0010",
                     out_instr_hi, out_instr_lo, out_group, out_pc);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0012)
            $display("FAIL g5_next: got req=%b addr=%h want 1/0012", mem_req, mem_addr);
        else n_pass++;
        wait_cycles = 0;
    endtask

    task automatic test_wrap();
        bit ok;
        int cyc;
        mem[16'hFFFF] = 16'hE1C3;
        mem[0] = 16'hA5A5;
        mem[1] = 16'h0ABC;
        wait_cycles = 0;
        out_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        @(negedge clk);
        redirect_valid = 1'b0;
        ack_q.delete();
        wait_valid(20, ok, cyc);
        n_total++;
        if (!ok || out_instr_hi !== 16'hE1C3 || out_instr_lo !== 16'hA5A5 ||
            out_group !== instr_grp_5 || out_pc !== 16'hFFFF)
            $display("FAIL wrap_issue: got ok=%b hi=%h lo=%h g=%0d pc=%h want 1/E1C3/A5A5/5/FFFF",
                     ok, out_instr_hi, out_instr_lo, out_group, out_pc);
        else n_pass++;
        n_total++;
        if (ack_q.size() != 2 || ack_q[0] !== 16'hFFFF || ack_q[1] !== 16'h0000)
            $display("FAIL wrap_addrs: got n=%0d first=%h want n=2 FFFF,0000",
                     ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : 16'hxxxx);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (mem_addr !== 16'h0001)
            $display("FAIL wrap_next: got addr=%h want 0001", mem_addr);
        else n_pass++;
    endtask

    task automatic test_redirect_lo();
        bit ok;
        bit seen;
        int cyc;
        mem[16'h20] = 16'hE000;
        mem[16'h21] = 16'h1111;
        mem[16'h100] = 16'h0042;
        wait_cycles = 3;
        out_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0020;
        @(negedge clk);
        redirect_valid = 1'b0;
        ack_q.delete();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (ack_q.size() > 0) seen = 1'b1;
        end
        n_total++;
        if (!seen) $display("FAIL rlo_hi_ack: got no ack want ack of 0020");
        else n_pass++;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_total++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0100 || out_valid !== 1'b0)
            $display("FAIL rlo_target: got req=%b addr=%h v=%b want 1/0100/0",
                     mem_req, mem_addr, out_valid);
        else n_pass++;
        wait_valid(20, ok, cyc);
        n_total++;
        if (!ok || out_pc !== 16'h0100 || out_instr_hi !== 16'h0042 ||
            out_instr_lo !== 16'h0 || out_group !== instr_grp_1)
            $display("FAIL rlo_issue: got ok=%b pc=%h hi=%h lo=%h g=%0d want 1/0100/0042/0000/1",
                     ok, out_pc, out_instr_hi, out_instr_lo, out_group);
        else n_pass++;
        wait_cycles = 0;
    endtask

    task automatic test_stall();
        bit ok;
        int cyc;
        mem[0] = 16'h4321;
        mem[16'h40] = 16'h0777;
        wait_cycles = 0;
        out_ready = 1'b0;
        do_reset();
        wait_valid(20, ok, cyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++;
            if (out_valid !== 1'b1 || mem_req !== 1'b0 || out_instr_hi !== 16'h4321 ||
                out_instr_lo !== 16'h0 || out_group !== instr_grp_1 || out_pc !== 16'h0)
                $display("FAIL stall_hold: got v=%b req=%b hi=%h lo=%h g=%0d pc=%h want 1/0/4321/0000/1/0000",
                         out_valid, mem_req, out_instr_hi, out_instr_lo, out_group, out_pc);
            else n_pass++;
        end
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0040)
            $display("FAIL stall_redir: got v=%b req=%b addr=%h want 0/1/0040",
                     out_valid, mem_req, mem_addr);
        else n_pass++;
        wait_valid(20, ok, cyc);
        n_total++;
        if (!ok || out_pc !== 16'h0040 || out_instr_hi !== 16'h0777)
            $display("FAIL stall_after: got ok=%b pc=%h hi=%h want 1/0040/0777",
                     ok, out_pc, out_instr_hi);
        else n_pass++;
    endtask

    task automatic test_unknown();
        bit ok;
        int cyc;
        mem[16'h300] = 16'hFC00;
        mem[16'h301] = 16'h0055;
        wait_cycles = 0;
        out_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0300;
        @(negedge clk);
        redirect_valid = 1'b0;
`ifdef INSTR_FETCH_TRAP_UNKNOWN_EN
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) begin
                redirect_valid = 1'b1;
                redirect_pc = 16'h0000;
            end else begin
                redirect_valid = 1'b0;
            end
            n_total++;
            if (illegal_instr !== 1'b1 || mem_req !== 1'b0 || out_valid !== 1'b0 ||
                out_pc !== 16'h0300)
                $display("FAIL unk_halt: got ill=%b req=%b v=%b pc=%h want 1/0/0/0300",
                         illegal_instr, mem_req, out_valid, out_pc);
            else n_pass++;
        end
        redirect_valid = 1'b0;
        do_reset();
        #2;
        n_total++;
        if (illegal_instr !== 1'b0 || mem_req !== 1'b1)
            $display("FAIL unk_reset: got ill=%b req=%b want 0/1", illegal_instr, mem_req);
        else n_pass++;
`else
        wait_valid(20, ok, cyc);
        n_total++;
        if (!ok || out_instr_hi !== 16'hFC00 || out_group !== instr_grp_unknown ||
            out_instr_lo !== 16'h0 || out_pc !== 16'h0300 || illegal_instr !== 1'b0)
            $display("FAIL unk_issue: got ok=%b hi=%h g=%0d lo=%h pc=%h ill=%b want 1/FC00/0/0000/0300/0",
                     ok, out_instr_hi, out_group, out_instr_lo, out_pc, illegal_instr);
        else n_pass++;
        wait_valid(20, ok, cyc);
        n_total++;
        if (!ok || out_pc !== 16'h0301 || out_instr_hi !== 16'h0055 ||
            out_group !== instr_grp_1)
            $display("FAIL unk_continue: got ok=%b pc=%h hi=%h g=%0d want 1/0301/0055/1",
                     ok, out_pc, out_instr_hi, out_group);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [15:0] m_pc;
        logic [15:0] nxt;
        logic [15:0] e_hi;
        logic [15:0] e_lo;
        instr_group  e_grp;
        int          done;
        for (int a = 0; a < 1024; a++) begin
            logic [15:0] w;
            w = 16'($urandom);
`ifdef INSTR_FETCH_TRAP_UNKNOWN_EN
            if (w >= 16'hE400) w[15] = 1'b0;
`endif
            mem[a] = w;
        end
        rand_wait = 1'b1;
        out_ready = 1'b0;
        do_reset();
        m_pc = 16'h0000;
        done = 0;
        for (int c = 0; c < 6000 && done < 150; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                e_hi = mem[m_pc];
                e_grp = ref_group(e_hi);
                nxt = m_pc + 16'd1;
                e_lo = (e_grp == instr_grp_5) ? mem[nxt] : 16'h0000;
                n_total++;
                if (out_instr_hi !== e_hi || out_instr_lo !== e_lo ||
                    out_group !== e_grp || out_pc !== m_pc)
                    $display("FAIL rand_instr: got hi=%h lo=%h g=%0d pc=%h want %h/%h/%0d/%h",
                             out_instr_hi, out_instr_lo, out_group, out_pc,
                             e_hi, e_lo, e_grp, m_pc);
                else n_pass++;
                m_pc = m_pc + ((e_grp == instr_grp_5) ? 16'd2 : 16'd1);
                done++;
            end
        end
        n_total++;
        if (done != 150)
            $display("FAIL rand_budget: got %0d instructions want 150", done);
        else n_pass++;
        rand_wait = 1'b0;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset_n = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        wait_cycles = 0;
        rand_wait = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        test_reset();
        test_single();
        test_group5_wait();
        test_wrap();
        test_redirect_lo();
        test_stall();
        test_unknown();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
